// File: rtl/axi4_sram_responder.sv
// AXI4 responder serving single-outstanding 32-bit INCR/FIXED bursts from a local synchronous SRAM.
// state | meaning: IDLE wait AW/AR | WRITE take W beats | WRESP hold B | READ stream R beats
module axi4_sram_responder #(
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inport_awvalid_i,
    input  logic [ADDR_W-1:0] inport_awaddr_i,
    input  logic [ID_W-1:0]   inport_awid_i,
    input  logic [7:0]        inport_awlen_i,
    input  logic [1:0]        inport_awburst_i,
    output logic              inport_awready_o,
    input  logic              inport_wvalid_i,
    input  logic [31:0]       inport_wdata_i,
    input  logic [3:0]        inport_wstrb_i,
    input  logic              inport_wlast_i,
    output logic              inport_wready_o,
    output logic              inport_bvalid_o,
    output logic [1:0]        inport_bresp_o,
    output logic [ID_W-1:0]   inport_bid_o,
    input  logic              inport_bready_i,
    input  logic              inport_arvalid_i,
    input  logic [ADDR_W-1:0] inport_araddr_i,
    input  logic [ID_W-1:0]   inport_arid_i,
    input  logic [7:0]        inport_arlen_i,
    input  logic [1:0]        inport_arburst_i,
    output logic              inport_arready_o,
    output logic              inport_rvalid_o,
    output logic [31:0]       inport_rdata_o,
    output logic [1:0]        inport_rresp_o,
    output logic [ID_W-1:0]   inport_rid_o,
    output logic              inport_rlast_o,
    input  logic              inport_rready_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_t;

    state_t           state_q;
    logic             prio_q;
    logic             fixed_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       len_q;
    logic [7:0]       cnt_q;
    logic [ID_W-1:0]  bid_q;
    logic [ID_W-1:0]  rid_q;
    logic             wready_q;
    logic             bvalid_q;
    logic             rvalid_q;
    logic             rlast_q;
    logic [31:0]      rdata_q;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             idle;
    logic             aw_hs;
    logic             ar_hs;
    logic             w_hs;
    logic             r_hs;
    logic             rd_en_d;
    logic [IDX_W-1:0] idx_next_d;
    logic [IDX_W-1:0] rd_idx_d;
    logic             unused_ok;

    // prio_q: 0 = write side wins a tie, 1 = read side wins
    assign idle             = (state_q == ST_IDLE);
    assign inport_awready_o = idle & inport_awvalid_i & (~inport_arvalid_i | ~prio_q);
    assign inport_arready_o = idle & inport_arvalid_i & (~inport_awvalid_i | prio_q);
    assign aw_hs            = inport_awvalid_i & inport_awready_o;
    assign ar_hs            = inport_arvalid_i & inport_arready_o;
    assign w_hs             = inport_wvalid_i & wready_q;
    assign r_hs             = rvalid_q & inport_rready_i;

    assign idx_next_d = fixed_q ? idx_q : idx_q + 1'b1;
    // Only fetch on a new burst or an accepted beat, so stalled R data never changes
    assign rd_en_d    = ar_hs | (r_hs & ~rlast_q);
    assign rd_idx_d   = ar_hs ? inport_araddr_i[IDX_W+1:2] : idx_next_d;

    assign inport_wready_o = wready_q;
    assign inport_bvalid_o = bvalid_q;
    assign inport_bresp_o  = 2'b00;
    assign inport_bid_o    = bid_q;
    assign inport_rvalid_o = rvalid_q;
    assign inport_rdata_o  = rdata_q;
    assign inport_rresp_o  = 2'b00;
    assign inport_rid_o    = rid_q;
    assign inport_rlast_o  = rlast_q;

    assign unused_ok = ^{inport_awlen_i,
                         inport_awaddr_i[ADDR_W-1:IDX_W+2], inport_awaddr_i[1:0],
                         inport_araddr_i[ADDR_W-1:IDX_W+2], inport_araddr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (w_hs && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (inport_wstrb_i[b]) begin
                    mem_q[idx_q][8*b +: 8] <= inport_wdata_i[8*b +: 8];
                end
            end
        end
        if (rd_en_d) begin
            rdata_q <= mem_q[rd_idx_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            fixed_q  <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            bid_q    <= '0;
            rid_q    <= '0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (aw_hs) begin
                        state_q  <= ST_WRITE;
                        wready_q <= 1'b1;
                        idx_q    <= inport_awaddr_i[IDX_W+1:2];
                        fixed_q  <= (inport_awburst_i == 2'b00);
                        bid_q    <= inport_awid_i;
                        if (inport_arvalid_i) begin
                            prio_q <= 1'b1;
                        end
                    end else if (ar_hs) begin
                        state_q  <= ST_READ;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (inport_arlen_i == 8'd0);
                        cnt_q    <= 8'd0;
                        len_q    <= inport_arlen_i;
                        idx_q    <= inport_araddr_i[IDX_W+1:2];
                        fixed_q  <= (inport_arburst_i == 2'b00);
                        rid_q    <= inport_arid_i;
                        if (inport_awvalid_i) begin
                            prio_q <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_hs) begin
                        idx_q <= idx_next_d;
                        if (inport_wlast_i) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            state_q  <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (inport_bready_i) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_next_d;
                            cnt_q   <= cnt_q + 8'd1;
                            rlast_q <= ((cnt_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Scoreboard bench for axi4_sram_responder: expected read words are queued when a read
// is issued and popped as R beats arrive.
module tb_axi4_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wbuf[16];

    always #5 clk = ~clk;

    axi4_sram_responder #(.ADDR_W(32), .ID_W(4), .DEPTH_WORDS(1024)) dut (
        .clk_i(clk), .rst_i(rst),
        .inport_awvalid_i(awvalid), .inport_awaddr_i(awaddr), .inport_awid_i(awid),
        .inport_awlen_i(awlen), .inport_awburst_i(awburst), .inport_awready_o(awready),
        .inport_wvalid_i(wvalid), .inport_wdata_i(wdata), .inport_wstrb_i(wstrb),
        .inport_wlast_i(wlast), .inport_wready_o(wready),
        .inport_bvalid_o(bvalid), .inport_bresp_o(bresp), .inport_bid_o(bid),
        .inport_bready_i(bready),
        .inport_arvalid_i(arvalid), .inport_araddr_i(araddr), .inport_arid_i(arid),
        .inport_arlen_i(arlen), .inport_arburst_i(arburst), .inport_arready_o(arready),
        .inport_rvalid_o(rvalid), .inport_rdata_o(rdata), .inport_rresp_o(rresp),
        .inport_rid_o(rid), .inport_rlast_o(rlast), .inport_rready_i(rready)
    );

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst;
        #1;
        while (!awready && n < 100) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (awready !== 1'b1) begin n_fail++; $display("FAIL aw_accept: awready=%b required 1", awready); end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [7:0] len, input logic [3:0] strb);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len));
            #1;
            while (!wready && n < 100) begin @(posedge clk); #1; n++; end
            n_checks++;
            if (wready !== 1'b1) begin n_fail++; $display("FAIL w_accept beat %0d: wready=%b required 1", i, wready); end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id);
        int n = 0;
        bready = 1'b1;
        #1;
        while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== id) begin
            n_fail++;
            $display("FAIL b_resp: bvalid=%b bresp=%b bid=%h required 1 00 %h", bvalid, bresp, bid, id);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL b_drop: bvalid=%b required 0", bvalid); end
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
        #1;
        while (!arready && n < 100) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (arready !== 1'b1) begin n_fail++; $display("FAIL ar_accept: arready=%b required 1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL r_latency: rvalid=%b required 1", rvalid); end
    endtask

    task automatic r_phase(input logic [3:0] id, input logic [7:0] len, input bit rnd);
        int          beats = 0;
        int          n = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        logic [31:0] e;
        while (beats <= int'(len) && n < 300) begin
            rready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rvalid && stalled) begin
                n_checks++;
                if (rdata !== held_d || rlast !== held_l) begin
                    n_fail++;
                    $display("FAIL r_stable: rdata=%h rlast=%b required %h %b", rdata, rlast, held_d, held_l);
                end
            end
            if (rvalid && rready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                n_checks++;
                if (rdata !== e || rresp !== 2'b00 || rid !== id || rlast !== (beats == int'(len))) begin
                    n_fail++;
                    $display("FAIL r_beat %0d: rdata=%h rresp=%b rid=%h rlast=%b required %h 00 %h %b",
                             beats, rdata, rresp, rid, rlast, e, id, (beats == int'(len)));
                end
                beats++;
                stalled = 1'b0;
            end else if (rvalid) begin
                stalled = 1'b1; held_d = rdata; held_l = rlast;
            end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0;
        n_checks++;
        if (beats != int'(len) + 1 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL r_end: beats=%0d rvalid=%b required %0d 0", beats, rvalid, int'(len) + 1);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb);
        aw_phase(addr, id, len, burst);
        w_phase(len, strb);
        b_phase(id);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit rnd);
        ar_phase(addr, id, len, burst);
        r_phase(id, len, rnd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({rvalid, bvalid, wready, rlast, awready, arready} !== 6'b0 || bid !== 4'h0 || rid !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: rv=%b bv=%b wr=%b rl=%b awr=%b arr=%b bid=%h rid=%h required all 0",
                     rvalid, bvalid, wready, rlast, awready, arready, bid, rid);
        end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        do_write(32'h100, 4'h3, 8'd3, 2'b01, 4'hF);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        do_read(32'h100, 4'h5, 8'd3, 2'b01, 1'b0);
        exp_q.push_back(32'hA0);
        do_read(32'h1100, 4'h6, 8'd0, 2'b01, 1'b0);
    endtask

    task automatic test_strb();
        wbuf[0] = 32'hDEADBEEF;
        do_write(32'h200, 4'h1, 8'd0, 2'b01, 4'hF);
        wbuf[0] = 32'h11223344;
        do_write(32'h200, 4'h2, 8'd0, 2'b01, 4'b0101);
        exp_q.push_back(32'hDE22BE44);
        do_read(32'h200, 4'h4, 8'd0, 2'b01, 1'b0);
    endtask

    task automatic test_fixed();
        wbuf[0] = 32'h55AA55AA;
        do_write(32'h304, 4'h8, 8'd0, 2'b01, 4'hF);
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
        do_write(32'h300, 4'h9, 8'd2, 2'b00, 4'hF);
        exp_q.push_back(32'd3); exp_q.push_back(32'h55AA55AA);
        do_read(32'h300, 4'hA, 8'd1, 2'b01, 1'b0);
        repeat (3) exp_q.push_back(32'd3);
        do_read(32'h300, 4'hB, 8'd2, 2'b00, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE0000 + i;
        do_write(32'h500, 4'hC, 8'd7, 2'b01, 4'hF);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE0000 + i);
        do_read(32'h500, 4'hD, 8'd7, 2'b01, 1'b1);
    endtask

    task automatic arb_round(input bit write_first, input logic [31:0] wval, input logic [31:0] old_val);
        wbuf[0] = wval;
        awvalid = 1'b1; awaddr = 32'h600; awid = 4'h7; awlen = 0; awburst = 2'b01;
        arvalid = 1'b1; araddr = 32'h600; arid = 4'h9; arlen = 0; arburst = 2'b01;
        #1;
        n_checks++;
        if (awready !== write_first || arready !== !write_first) begin
            n_fail++;
            $display("FAIL arb_pick: awready=%b arready=%b required %b %b", awready, arready, write_first, !write_first);
        end
        @(posedge clk); #1;
        if (write_first) begin
            awvalid = 1'b0;
            n_checks++;
            if (arready !== 1'b0) begin n_fail++; $display("FAIL arb_busy: arready=%b required 0", arready); end
            w_phase(8'd0, 4'hF);
            b_phase(4'h7);
            exp_q.push_back(wval);
            do_read(32'h600, 4'h9, 8'd0, 2'b01, 1'b0);
        end else begin
            arvalid = 1'b0;
            n_checks++;
            if (awready !== 1'b0 || rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL arb_busy: awready=%b rvalid=%b required 0 1", awready, rvalid);
            end
            exp_q.push_back(old_val);
            r_phase(4'h9, 8'd0, 1'b0);
            do_write(32'h600, 4'h7, 8'd0, 2'b01, 4'hF);
        end
    endtask

    task automatic test_arbitration();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        arb_round(1'b1, 32'h111, 32'h0);
        arb_round(1'b0, 32'h222, 32'h111);
        arb_round(1'b1, 32'h333, 32'h222);
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] e;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE0000 + i);
        ar_phase(32'h500, 4'hE, 8'd7, 2'b01);
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== e) begin
                n_fail++;
                $display("FAIL pre_reset beat %0d: rvalid=%b rdata=%h required 1 %h", i, rvalid, rdata, e);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rvalid, rlast, wready, bvalid} !== 4'b0 || rid !== 4'h0 || bid !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset: rvalid=%b rlast=%b wready=%b bvalid=%b rid=%h bid=%h required all 0",
                     rvalid, rlast, wready, bvalid, rid, bid);
        end
        rst = 1'b0; rready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE0000 + i);
        do_read(32'h500, 4'h2, 8'd7, 2'b01, 1'b0);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_strb();
        test_fixed();
        test_backpressure();
        test_arbitration();
        test_reset_mid_read();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
